dram_lsu: RTL
=============

# dram_lsu

Load/store unit between the RISC-V core's memory stage and the word-addressed data DRAM. The DRAM has a 10-bit word address, synchronous 1-cycle read and per-byte write enables. The block accepts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests and generates the word address, byte enables and lane-shifted store data. It returns aligned, sign- or zero-extended load data. Accesses that straddle a word boundary are split into two DRAM beats by a small FSM.

## Interface
- ADDR_W, 10, DRAM word-address width.
- SUPPORT_MISALIGNED, 1, if 1, word-crossing accesses are split into two beats; if 0, they are rejected with rsp_err.

- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- req_addr  in  32  byte address. Bits above ADDR_W+1 are ignored.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load result; 0 for stores, for errors, and whenever rsp_valid=0.
- rsp_err  out  1  illegal funct3, or a crossing access when SUPPORT_MISALIGNED=0.
- mem_addr  out  ADDR_W  DRAM word address.
- mem_wr_en  out  1  DRAM write strobe.
- mem_wr_byte_en  out  4  DRAM byte lanes.
- mem_wr_data  out  32  DRAM write data.
- mem_rd_data  in  32  DRAM read data, valid the cycle after mem_addr.

## Operation
- Request decode:
  - w = req_addr[ADDR_W+1:2]; off = req_addr[1:0].
  - Size is 1, 2 or 4 bytes.
  - cross = off + size > 4.
- Stores:
  - 8-byte mask = sizemask (0001/0011/1111) << off.
  - 64-bit data = req_wdata << 8*off.
  - Beat 1 drives mask[3:0] and data[31:0] to word w.
  - Beat 2 drives mask[7:4] and data[63:32] to word (w+1) mod 2^ADDR_W, i.e. 1023 wraps to 0.
- Loads:
  - Beat 1 reads word w.
  - If the access crosses, the beat-1 word is captured into lo_q and beat 2 reads w+1.
  - Result = ({hi, lo} >> 8*off), truncated to size, then sign-extended (LB/LH) or zero-extended (LBU/LHU).
  - For a non-crossing load, lo = mem_rd_data and hi is don't-care.
- Errors:
  - Illegal funct3: loads 011/110/111; stores 1xx or 011.
  - Crossing access with SUPPORT_MISALIGNED=0.
  - An error performs no DRAM write, and the response carries rsp_err=1 and rsp_rdata=0.
- FSM states: IDLE, SECOND, FINISH.
  - IDLE: req_ready=1. The mem_* outputs are driven combinationally from the request, issuing beat 1 in the accept cycle. mem_wr_en = req_valid && req_we && !err. On accept: cross → SECOND, else → FINISH.
  - SECOND: req_ready=0. Issues beat 2 from the registered op, w+1, mask and data. Loads capture lo_q here. → FINISH.
  - FINISH: rsp_valid=1, and rsp_rdata/rsp_err are formatted from mem_rd_data and the registered op. req_ready=1. An accept here behaves exactly as in IDLE; otherwise → IDLE.
- When no access is issued, mem_wr_en=0, mem_wr_byte_en=0 and mem_addr holds the last value. Reads are harmless.

## Timing
- Non-crossing access: accept in cycle N → rsp_valid in N+1. Back-to-back throughput is 1 request/cycle.
- Crossing access: accept in N, beat 2 in N+1, rsp_valid in N+2.
- A load immediately after a store to the same word sees the new data, because the write occurs at edge N and the read at edge N+1.
- Reset values: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, lo_q=0, and all op registers 0.
- While rst=1: req_ready=0 and mem_wr_en=0.
- Reset asserted in SECOND abandons beat 2. A crossing store may then be half-written; this is accepted behaviour and no response is produced.
- rsp_valid is never held for more than one cycle, and there is no back-pressure on the response.

## Structure
- Package lsu_pkg contains:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state enum (IDLE/SECOND/FINISH);
  - function size_mask(funct3) → 4'b0001/0011/1111;
  - function f3_legal(we, funct3).
- Sub-module lsu_load_format: purely combinational. Inputs {hi, lo}, off and funct3; output is the extended 32-bit result.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10:
  - mem_addr=4, byte_en=1111.
  - rsp_rdata=0xDEADBEEF one cycle after the load is accepted.
- SB 0x80 @0x13, then LB and LBU @0x13:
  - byte_en=1000, wr_data[31:24]=0x80.
  - LB returns 0xFFFFFF80; LBU returns 0x00000080.
- SH 0xA55A @0x17 (crossing), then LH @0x17:
  - Beat 1: addr 5, be=1000, data[31:24]=0x5A.
  - Beat 2: addr 6, be=0001, data[7:0]=0xA5.
  - LH returns 0xFFFFA55A; rsp_valid 2 cycles after accept.
- Wrap-around and back-to-back:
  - LW @0xFFE: beat 1 addr 1023, beat 2 addr 0, result {mem[0][15:0], mem[1023][31:16]}.
  - 4 back-to-back aligned LWs give 4 consecutive rsp_valid cycles.
- Error responses:
  - funct3=011 load, and a store with funct3=100: rsp_err=1, rsp_rdata=0, mem_wr_en never asserted.
  - With SUPPORT_MISALIGNED=0, SW @0x2: rsp_err=1 one cycle after accept, no write.
- Reset mid-access:
  - Assert rst in SECOND of a crossing SW.
  - Next cycle: state IDLE, rsp_valid=0, beat 2 never written, beat-1 bytes present in DRAM.

Source files
------------

// File: rtl/dram_lsu_pkg.sv
// rtl/dram_lsu_pkg.sv - shared funct3 codes, FSM states and decode helpers for the DRAM load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SECOND = 2'd1,
        FINISH = 2'd2
    } lsu_state_e;

    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
        if (we) begin
            return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end
        return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
               (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

endpackage

// File: rtl/dram_lsu_if.sv
// rtl/dram_lsu_if.sv - request/response and DRAM port bundle for the load/store unit.
interface dram_lsu_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_en;
    logic [3:0]        mem_wr_byte_en;
    logic [31:0]       mem_wr_data;
    logic [31:0]       mem_rd_data;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_wr_en, mem_wr_byte_en, mem_wr_data
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_wr_en, mem_wr_byte_en, mem_wr_data
    );
endinterface

// File: rtl/dram_lsu_load_format.sv
// rtl/dram_lsu_load_format.sv - aligns a two-word load window and sign/zero-extends to 32 bits.
module lsu_load_format
    import lsu_pkg::*;
(
    input  logic [63:0] data,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    assign shifted = 32'(data >> {off, 3'b000});

    always_comb begin
        case (funct3)
            F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   rdata = {24'h0, shifted[7:0]};
            F3_HU:   rdata = {16'h0, shifted[15:0]};
            default: rdata = shifted;
        endcase
    end

endmodule

// File: rtl/dram_lsu.sv
// rtl/dram_lsu.sv - byte-addressed load/store unit in front of a word-addressed DRAM;
// word-crossing accesses are split into two beats.
module dram_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W             = 10,
    parameter bit SUPPORT_MISALIGNED = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    dram_lsu_if.slave  bus
);

    lsu_state_e        state_q, state_d;
    logic              op_we_q, op_we_d;
    logic [2:0]        op_f3_q, op_f3_d;
    logic [1:0]        op_off_q, op_off_d;
    logic [ADDR_W-1:0] op_w_q, op_w_d;
    logic [3:0]        op_mask_hi_q, op_mask_hi_d;
    logic [31:0]       op_data_hi_q, op_data_hi_d;
    logic              op_err_q, op_err_d;
    logic              op_cross_q, op_cross_d;
    logic [31:0]       lo_q, lo_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;

    logic [ADDR_W-1:0] req_w;
    logic [1:0]        req_off;
    logic [3:0]        req_mask;
    logic [2:0]        req_size;
    logic              req_legal;
    logic              req_cross;
    logic              req_err;
    logic              req_split;
    logic [7:0]        req_mask8;
    logic [63:0]       req_data64;
    logic              can_accept;
    logic              req_fire;

    logic [ADDR_W-1:0] mem_addr_c;
    logic              mem_wr_en_c;
    logic [3:0]        mem_be_c;
    logic [31:0]       mem_wd_c;

    logic              rsp_valid_c;
    logic [63:0]       fmt_in;
    logic [31:0]       fmt_out;
    logic              unused_addr_hi;

    assign req_w      = bus.req_addr[ADDR_W+1:2];
    assign req_off    = bus.req_addr[1:0];
    assign req_mask   = size_mask(bus.req_funct3);
    assign req_size   = (req_mask == 4'b0001) ? 3'd1 :
                        (req_mask == 4'b0011) ? 3'd2 : 3'd4;
    assign req_legal  = f3_legal(bus.req_we, bus.req_funct3);
    // Illegal ops never split, so they always answer in the next cycle.
    assign req_cross  = req_legal && (({1'b0, req_off} + req_size) > 3'd4);
    assign req_err    = !req_legal || (req_cross && !SUPPORT_MISALIGNED);
    assign req_split  = req_cross && SUPPORT_MISALIGNED;
    assign req_mask8  = {4'h0, req_mask} << req_off;
    assign req_data64 = {32'h0, bus.req_wdata} << {req_off, 3'b000};

    assign can_accept = !rst && (state_q != SECOND);
    assign req_fire   = bus.req_valid && can_accept;

    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

    always_comb begin
        state_d      = state_q;
        op_we_d      = op_we_q;
        op_f3_d      = op_f3_q;
        op_off_d     = op_off_q;
        op_w_d       = op_w_q;
        op_mask_hi_d = op_mask_hi_q;
        op_data_hi_d = op_data_hi_q;
        op_err_d     = op_err_q;
        op_cross_d   = op_cross_q;
        lo_d         = lo_q;
        mem_addr_c   = last_addr_q;
        mem_wr_en_c  = 1'b0;
        mem_be_c     = 4'h0;
        mem_wd_c     = 32'h0;

        if (state_q == SECOND) begin
            mem_addr_c = op_w_q + ADDR_W'(1);
            if (op_we_q) begin
                mem_wr_en_c = 1'b1;
                mem_be_c    = op_mask_hi_q;
                mem_wd_c    = op_data_hi_q;
            end else begin
                lo_d = bus.mem_rd_data;
            end
            state_d = FINISH;
        end else begin
            state_d = IDLE;
            if (req_fire) begin
                mem_addr_c  = req_w;
                mem_wr_en_c = bus.req_we && !req_err;
                if (mem_wr_en_c) begin
                    mem_be_c = req_mask8[3:0];
                    mem_wd_c = req_data64[31:0];
                end
                op_we_d      = bus.req_we;
                op_f3_d      = bus.req_funct3;
                op_off_d     = req_off;
                op_w_d       = req_w;
                op_mask_hi_d = req_mask8[7:4];
                op_data_hi_d = req_data64[63:32];
                op_err_d     = req_err;
                op_cross_d   = req_split;
                state_d      = req_split ? SECOND : FINISH;
            end
        end

        last_addr_d = mem_addr_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            op_we_q      <= 1'b0;
            op_f3_q      <= 3'h0;
            op_off_q     <= 2'h0;
            op_w_q       <= '0;
            op_mask_hi_q <= 4'h0;
            op_data_hi_q <= 32'h0;
            op_err_q     <= 1'b0;
            op_cross_q   <= 1'b0;
            lo_q         <= 32'h0;
            last_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            op_we_q      <= op_we_d;
            op_f3_q      <= op_f3_d;
            op_off_q     <= op_off_d;
            op_w_q       <= op_w_d;
            op_mask_hi_q <= op_mask_hi_d;
            op_data_hi_q <= op_data_hi_d;
            op_err_q     <= op_err_d;
            op_cross_q   <= op_cross_d;
            lo_q         <= lo_d;
            last_addr_q  <= last_addr_d;
        end
    end

    // In FINISH the DRAM read port carries the last beat of the registered op.
    assign rsp_valid_c = (state_q == FINISH);
    assign fmt_in      = op_cross_q ? {bus.mem_rd_data, lo_q} : {32'h0, bus.mem_rd_data};

    lsu_load_format u_load_format (
        .data   (fmt_in),
        .off    (op_off_q),
        .funct3 (op_f3_q),
        .rdata  (fmt_out)
    );

    assign bus.req_ready      = can_accept;
    assign bus.rsp_valid      = rsp_valid_c;
    assign bus.rsp_err        = rsp_valid_c && op_err_q;
    assign bus.rsp_rdata      = (rsp_valid_c && !op_we_q && !op_err_q) ? fmt_out : 32'h0;
    assign bus.mem_addr       = mem_addr_c;
    assign bus.mem_wr_en      = mem_wr_en_c;
    assign bus.mem_wr_byte_en = mem_be_c;
    assign bus.mem_wr_data    = mem_wd_c;

endmodule
